long_multiplier: RTL and testbench
==================================

# long_multiplier

Sequential shift-add reconstruction unit: the inverse of `long_divider`. It takes a divisor `M`, a quotient `Q` and a remainder `R` and rebuilds the dividend `D = Q*M + R` over four clock cycles, using one 4-bit partial product per cycle. It sits beside the divider as its round-trip checker: divider outputs feed this block, and the rebuilt `D` is compared against the original dividend. Operands are captured on a start handshake, and the result is presented with a one-cycle `done` pulse.

## Interface
Parameters: none. All widths are fixed by the divider: 4-bit `M`, `Q`, `R`; 8-bit `D`.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge
- `rst`  input  1  — asynchronous, active-high reset
- `start`  input  1  — request; sampled only while idle (`busy`=0)
- `M`  input  4  — divisor (multiplicand), unsigned
- `Q`  input  4  — quotient (multiplier), unsigned
- `R`  input  4  — remainder (initial accumulator), unsigned
- `busy`  output  1  — operation in progress
- `done`  output  1  — one-cycle pulse; `D` and `err` valid from this cycle
- `D`  output  8  — reconstructed dividend, registered; held until the next `done`
- `err`  output  1  — registered; 1 when the captured triple is not a legal divider result (`R >= M`, which includes `M`=0)

## Operation
- States: IDLE and RUN, plus a 2-bit step counter `cnt`.
- Internal registers:
  - `acc[7:0]` — accumulator
  - `mcand[7:0]` — shifted multiplicand
  - `mplr[3:0]` — multiplier, shifted right each step
  - `err_q` — captured error flag
- IDLE, `start`=1: capture the operands, set `busy`=1, go to RUN.
  - `acc`←{4'b0,`R`}
  - `mcand`←{4'b0,`M`}
  - `mplr`←`Q`
  - `err_q`←(`R`>=`M`)
  - `cnt`←0
- IDLE, `start`=0: hold all state; `D` and `err` keep their last values.
- RUN, each edge:
  - `acc`←`acc` + (`mplr[0]` ? `mcand` : 0)
  - `mcand`←`mcand`<<1
  - `mplr`←`mplr`>>1
  - `cnt`←`cnt`+1
- RUN with `cnt`==3 (final step): additionally, on the same edge:
  - `D`←the updated accumulator value
  - `err`←`err_q`
  - `done`←1, `busy`←0
  - state←IDLE
- Arithmetic:
  - Unsigned throughout; an 8-bit accumulator cannot overflow (max 15*15+15 = 240).
  - `mcand` bits shifted beyond bit 7 are never needed; after step 3, `mcand` ≤ 120.
- `start` while `busy`=1: ignored; no queuing. Operand changes during RUN have no effect.
- `start` asserted in the `done` cycle: accepted, because the FSM is already in IDLE. `done` still drops on the next edge while `busy` rises.
- `err` is informational only; `D` is computed regardless.
- Reset (asynchronous, any state, including mid-RUN):
  - state←IDLE, `cnt`←0
  - `acc`, `mcand`, `mplr`, `err_q`←0
  - outputs: `busy`=0, `done`=0, `D`=8'h00, `err`=0
  - An interrupted operation produces no `done`.

## Timing
- Edge 0: `start` sampled in IDLE; `busy` is high from edge 0.
- Edges 1–4: the four RUN steps.
- Edge 4: `D`, `err` and `done`=1 update together; `busy` falls.
- Edge 5: `done` falls.
- Latency: 4 cycles from the accepting edge to `done`.
- Throughput: one operation per 5 cycles (start re-asserted in the `done` cycle).
- `done` is never high for two consecutive cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.
- `rst` takes effect immediately, independent of `clk`. Release is synchronous in effect: the first active edge after deassertion may accept `start`.

## Test plan
- `M`=7, `Q`=5, `R`=3, one-cycle `start` → `busy` for 4 cycles, then `done` pulse with `D`=8'h26 (38), `err`=0.
- `M`=15, `Q`=15, `R`=14 → `D`=8'hEF (239), `err`=0. Then `M`=9, `Q`=0, `R`=4 → `D`=8'h04. Then `M`=3, `Q`=2, `R`=5 → `D`=8'h0B, `err`=1. Then `M`=0, `Q`=6, `R`=0 → `D`=0, `err`=1.
- Start `M`=7, `Q`=5, `R`=3. Two cycles later, pulse `start` again with `M`=1, `Q`=1, `R`=0 and change the operand inputs → single `done` with `D`=38; no second `done`.
- Back-to-back: hold `start`=1 continuously with fixed operands → `done` every 5th cycle, `D` correct each time, `busy`/`done` never overlap.
- Assert `rst` asynchronously mid-RUN (between edges 2 and 3) → `busy`, `done`, `D`, `err` go to 0 immediately. After release, no `done` appears until a new `start`; a new op `M`=4, `Q`=3, `R`=1 gives `D`=13.
- Random round-trip: drive random 7-bit dividends and nonzero 4-bit divisors whose true quotient is ≤ 15 into `long_divider`, and feed its `Q`, `R` with `M` here → `D` equals the original dividend and `err`=0 for every vector.

Source files
------------

// File: rtl/long_multiplier.sv
// Shift-add reconstruction of a divider's dividend: D = Q*M + R, one 4-bit
// partial product per cycle over four RUN cycles, with a one-cycle done pulse.
module long_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] M,
  input  logic [3:0] Q,
  input  logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic [7:0] D,
  output logic       err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [7:0] acc, acc_nxt;
  logic [7:0] mcand, mcand_nxt;
  logic [3:0] mplr, mplr_nxt;
  logic       err_q, err_q_nxt;
  logic       busy_nxt, done_nxt, err_nxt;
  logic [7:0] d_nxt;
  logic [7:0] acc_sum;

  // Accumulator after the current step; the final step writes this straight into D.
  assign acc_sum = acc + (mplr[0] ? mcand : 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      acc   <= 8'd0;
      mcand <= 8'd0;
      mplr  <= 4'd0;
      err_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= 8'd0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      mplr  <= mplr_nxt;
      err_q <= err_q_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      D     <= d_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    mcand_nxt = mcand;
    mplr_nxt  = mplr;
    err_q_nxt = err_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    d_nxt     = D;
    err_nxt   = err;

    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = {4'b0, R};
          mcand_nxt = {4'b0, M};
          mplr_nxt  = Q;
          err_q_nxt = (R >= M);
          cnt_nxt   = 2'd0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_nxt   = acc_sum;
        mcand_nxt = mcand << 1;
        mplr_nxt  = mplr >> 1;
        cnt_nxt   = cnt + 2'd1;
        if (cnt == 2'd3) begin
          d_nxt     = acc_sum;
          err_nxt   = err_q;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_long_multiplier.sv
// Scoreboard bench for long_multiplier: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_long_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] M, Q, R;
  logic       busy, done, err;
  logic [7:0] D;

  typedef struct packed {
    logic [7:0] d;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_seen = 0;

  long_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .M    (M),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .D    (D),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      check("busy_done_overlap", {7'b0, busy}, 8'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("D", D, e.d);
        check("err", {7'b0, err}, {7'b0, e.err});
      end
    end
  end

  // Issue one operation, then wait (bounded) for done and check latency.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [3:0] r,
                        input logic [7:0] d_exp, input logic err_exp);
    int n;
    @(negedge clk);
    M = m; Q = q; R = r; start = 1'b1;
    exp_q.push_back('{d: d_exp, err: err_exp});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {7'b0, busy}, 8'd1);
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 8'd0, 8'd1);
    else check("latency", n[7:0], 8'd4);
  endtask

  initial begin
    int n;
    int d_src, m_src;
    int done_cyc[3];
    int k;

    rst = 1'b1; start = 1'b0; M = '0; Q = '0; R = '0;
    #12;
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_done", {7'b0, done}, 8'd0);
    check("rst_D", D, 8'd0);
    check("rst_err", {7'b0, err}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    run_op(4'd7,  4'd5,  4'd3,  8'h26, 1'b0);
    run_op(4'd15, 4'd15, 4'd14, 8'hEF, 1'b0);
    run_op(4'd9,  4'd0,  4'd4,  8'h04, 1'b0);
    run_op(4'd3,  4'd2,  4'd5,  8'h0B, 1'b1);
    run_op(4'd0,  4'd6,  4'd0,  8'h00, 1'b1);

    // Second start during RUN is ignored and operand changes have no effect.
    @(negedge clk);
    M = 4'd7; Q = 4'd5; R = 4'd3; start = 1'b1;
    exp_q.push_back('{d: 8'd38, err: 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    M = 4'd1; Q = 4'd1; R = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; M = 4'd2; Q = 4'd9; R = 4'd1;
    n = done_seen;
    repeat (10) @(negedge clk);
    check("ignored_start_done_count", 8'(done_seen - n), 8'd1);

    // Back-to-back: start held high, done every fifth cycle.
    M = 4'd11; Q = 4'd13; R = 4'd2; start = 1'b1;
    repeat (3) exp_q.push_back('{d: 8'h91, err: 1'b0});
    k = 0; n = 0;
    while (k < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        done_cyc[k] = n;
        k++;
      end
    end
    start = 1'b0;
    if (k < 3) begin
      check("b2b_timeout", 8'(k), 8'd3);
    end else begin
      check("b2b_first", 8'(done_cyc[0]), 8'd5);
      check("b2b_gap1", 8'(done_cyc[1] - done_cyc[0]), 8'd5);
      check("b2b_gap2", 8'(done_cyc[2] - done_cyc[1]), 8'd5);
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset between RUN edges 2 and 3.
    @(negedge clk);
    M = 4'd7; Q = 4'd5; R = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy", {7'b0, busy}, 8'd0);
    check("async_done", {7'b0, done}, 8'd0);
    check("async_D", D, 8'd0);
    check("async_err", {7'b0, err}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    n = done_seen;
    repeat (8) @(negedge clk);
    check("no_done_after_reset", 8'(done_seen - n), 8'd0);
    run_op(4'd4, 4'd3, 4'd1, 8'd13, 1'b0);

    // Round trip against a bench-side division model of the divider.
    for (int i = 0; i < 8; i++) begin
      do begin
        d_src = $urandom_range(0, 127);
        m_src = $urandom_range(1, 15);
      end while (d_src / m_src > 15);
      run_op(4'(m_src), 4'(d_src / m_src), 4'(d_src % m_src), 8'(d_src), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
